fetch_redirect_arbiter: RTL and testbench
=========================================

# fetch_redirect_arbiter

Collects PC-redirect requests from the ROB flush path and the four JALR-capable execution units and presents exactly one redirect at a time to the instruction-fetch unit over a valid/ack handshake. Sits between the execute/commit back end and the `ir` fetch stage, replacing direct per-unit redirect wiring. Branch-mispredict flushes always win; pending JALR targets are buffered per unit and granted round-robin. All pending JALR state is discarded on flush.

## Interface
- Parameters:
- `NUM_JALR`, 4: number of JALR reporting units; fixed at 4 for this revision.
- Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `flush_req`  in  1  ROB mispredict flush request, one-cycle pulse.
- `flush_pc`  in  32  correct target PC for `flush_req`.
- `jalr_valid`  in  4  per-unit JALR-resolved pulse; bit i = unit i.
- `jalr_pc`  in  4x32  per-unit computed JALR target.
- `redirect_ack`  in  1  fetch unit consumed the presented redirect.
- `redirect_valid`  out  1  a redirect is being presented.
- `redirect_pc`  out  32  target PC; stable while `redirect_valid` and not acked.
- `redirect_src`  out  2  `redirect_src_t`: NONE, FLUSH, JALR.
- `flush_active`  out  1  presented redirect is a flush.
- `jalr_overrun`  out  1  sticky: a unit reported while its slot was still pending.

## Operation
- Per-unit JALR slot: valid bit + 32-bit PC. `jalr_valid[i]` sets slot i and writes PC; if slot already valid, PC overwritten and `jalr_overrun` set (cleared only by `rst`).
- Flush register: valid bit + PC. `flush_req` sets it; a second flush before ack overwrites PC.
- FSM states: IDLE, HOLD_JALR, HOLD_FLUSH.
- IDLE: flush pending -> HOLD_FLUSH; else any JALR slot valid -> HOLD_JALR, granting per round-robin; else stay.
- HOLD_JALR: `flush_req` -> HOLD_FLUSH (JALR output withdrawn without ack); `redirect_ack` -> clear granted slot, advance pointer, -> IDLE.
- HOLD_FLUSH: `redirect_ack` -> clear flush register -> IDLE; a new `flush_req` in the same cycle as ack re-sets the register (next cycle IDLE sees it).
- Any `flush_req`: clears all JALR slots and any `jalr_valid` arriving the same cycle (younger than the mispredict, discarded).
- Round-robin: 2-bit `rr_ptr` names highest-priority unit; search ptr, ptr+1, ... mod 4; after ack of unit g, `rr_ptr <= (g+1) mod 4`.
- Output registered: `redirect_pc`/`redirect_src` loaded on state entry.

## Timing
- Reset values: `redirect_valid`=0, `redirect_pc`=0x0000_0000, `redirect_src`=NONE, `flush_active`=0, `jalr_overrun`=0, `rr_ptr`=0, all slots/flush invalid, state IDLE.
- Latency: request at cycle N -> slot/flush reg at N+1 (IDLE) -> `redirect_valid` at N+2.
- Ack sampled only when `redirect_valid`=1; ack without valid ignored.
- Min spacing between two presented redirects: 1 idle cycle (IDLE visited after every ack).
- Flush preempting HOLD_JALR: flush at N -> `redirect_pc`=flush PC at N+2, `redirect_valid` stays 1 throughout.
- `rst` mid-handshake: all state cleared next edge; pending requests lost.

## Structure
- Add `redirect_src_t` enum (NONE, FLUSH, JALR) to `tomasula_types`.
- Sub-module `rr_arbiter4`: 4-bit request, 2-bit pointer in, one-hot grant + 2-bit index out, purely combinational.
- FSM, slots, flush register and overrun flag in the top module.

## Test plan
- Reset, then `jalr_valid`=0010, `jalr_pc[1]`=0x0000_0200 -> `redirect_valid` 2 cycles later, pc=0x200, src=JALR; ack -> valid drops, `rr_ptr`=2.
- `jalr_valid`=1111 with PCs 0x100/0x200/0x300/0x400, ack each -> order 0x100,0x200,0x300,0x400 from `rr_ptr`=0.
- HOLD_JALR presenting 0x300, `flush_req` pc=0x0000_0080 -> next presented pc=0x80, src=FLUSH, all slots empty after ack.
- Same-cycle `flush_req`(0x90) and `jalr_valid`=0001 -> only 0x90 presented; no JALR afterwards.
- Flush ack coincident with new `flush_req`(0xA0) -> valid low one cycle, then pc=0xA0 presented.
- `jalr_valid[2]` twice without ack (0x500 then 0x600) -> presented pc=0x600, `jalr_overrun`=1 until `rst`.

Source files
------------

// File: rtl/tomasula_types.sv
// Shared types for the fetch redirect path: redirect source encoding and
// the state type of the redirect arbiter FSM.
package tomasula_types;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        REDIR_NONE  = 2'd0,
        REDIR_FLUSH = 2'd1,
        REDIR_JALR  = 2'd2
    } redirect_src_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOLD_JALR  = 2'd1,
        ST_HOLD_FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fetch_redirect_arbiter_rr_arbiter4.sv
// Four-way round-robin picker: the unit named by ptr has highest priority,
// then ptr+1, ptr+2, ptr+3 (mod 4). Purely combinational.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        grant = 4'b0000;
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// Merges ROB flush redirects and four buffered JALR targets into a single
// registered valid/ack redirect stream toward instruction fetch.
module fetch_redirect_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_JALR = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_req,
    input  logic [31:0]              flush_pc,
    input  logic [NUM_JALR-1:0]      jalr_valid,
    input  logic [32*NUM_JALR-1:0]   jalr_pc,
    input  logic                     redirect_ack,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic [1:0]               redirect_src,
    output logic                     flush_active,
    output logic                     jalr_overrun
);

    arb_state_t      state, state_nxt;
    logic [3:0]      slot_vld;
    logic [3:0][31:0] slot_pc;
    logic            flush_vld;
    logic [31:0]     flush_pc_q;
    logic [1:0]      rr_ptr;
    logic [3:0]      gnt_oh;
    logic [1:0]      gnt_idx;
    logic [1:0]      held_idx;
    logic            held_rewrite;
    logic [31:0]     pc_q;
    redirect_src_t   src_q;
    logic            overrun_q;
    logic            jalr_ack;
    logic [3:0]      slot_clr;

    rr_arbiter4 u_rr (
        .req   (slot_vld),
        .ptr   (rr_ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    // A flush in flight (pulse or pending register) outranks any JALR ack.
    assign jalr_ack = (state == ST_HOLD_JALR) && redirect_ack && !flush_req && !flush_vld;

    always_comb begin
        state_nxt = state;
        slot_clr  = 4'b0000;
        // A slot rewritten while being presented keeps its newer target.
        if (jalr_ack && !held_rewrite)
            slot_clr[held_idx] = 1'b1;
        case (state)
            ST_IDLE: begin
                if (flush_vld)
                    state_nxt = ST_HOLD_FLUSH;
                else if (!flush_req && |gnt_oh)
                    state_nxt = ST_HOLD_JALR;
            end
            ST_HOLD_JALR: begin
                if (flush_req)
                    state_nxt = ST_HOLD_JALR;
                else if (flush_vld)
                    state_nxt = ST_HOLD_FLUSH;
                else if (redirect_ack)
                    state_nxt = ST_IDLE;
            end
            ST_HOLD_FLUSH: begin
                if (redirect_ack)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            slot_vld     <= 4'b0000;
            slot_pc      <= '0;
            flush_vld    <= 1'b0;
            flush_pc_q   <= 32'h0;
            rr_ptr       <= 2'd0;
            held_idx     <= 2'd0;
            held_rewrite <= 1'b0;
            pc_q         <= 32'h0;
            src_q        <= REDIR_NONE;
            overrun_q    <= 1'b0;
        end else begin
            state <= state_nxt;

            // The flush register is consumed when its PC moves to the output.
            if (flush_req) begin
                flush_vld  <= 1'b1;
                flush_pc_q <= flush_pc;
            end else if (state != ST_HOLD_FLUSH && state_nxt == ST_HOLD_FLUSH) begin
                flush_vld <= 1'b0;
            end

            for (int i = 0; i < 4; i++) begin
                if (flush_req) begin
                    slot_vld[i] <= 1'b0;
                end else if (jalr_valid[i]) begin
                    slot_vld[i] <= 1'b1;
                    slot_pc[i]  <= jalr_pc[32*i +: 32];
                    if (slot_vld[i] && !slot_clr[i])
                        overrun_q <= 1'b1;
                end else if (slot_clr[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end

            if (jalr_ack)
                rr_ptr <= held_idx + 2'd1;

            if (state == ST_IDLE && state_nxt == ST_HOLD_JALR) begin
                held_idx     <= gnt_idx;
                held_rewrite <= jalr_valid[gnt_idx];
            end else if (state == ST_HOLD_JALR && jalr_valid[held_idx]) begin
                held_rewrite <= 1'b1;
            end

            if (state_nxt != state) begin
                case (state_nxt)
                    ST_HOLD_FLUSH: begin
                        pc_q  <= flush_pc_q;
                        src_q <= REDIR_FLUSH;
                    end
                    ST_HOLD_JALR: begin
                        pc_q  <= slot_pc[gnt_idx];
                        src_q <= REDIR_JALR;
                    end
                    default: src_q <= REDIR_NONE;
                endcase
            end
        end
    end

    assign redirect_valid = (state != ST_IDLE);
    assign flush_active   = (state == ST_HOLD_FLUSH);
    assign redirect_pc    = pc_q;
    assign redirect_src   = src_q;
    assign jalr_overrun   = overrun_q;

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// Self-checking bench for fetch_redirect_arbiter: per-cycle vector table with
// a scoreboard queue, followed by hand-written latency and reset sequences.
module tb_fetch_redirect_arbiter;

    logic         clk;
    logic         rst;
    logic         flush_req;
    logic [31:0]  flush_pc;
    logic [3:0]   jalr_valid;
    logic [127:0] jalr_pc;
    logic         redirect_ack;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [1:0]   redirect_src;
    logic         flush_active;
    logic         jalr_overrun;

    fetch_redirect_arbiter #(.NUM_JALR(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_req      (flush_req),
        .flush_pc       (flush_pc),
        .jalr_valid     (jalr_valid),
        .jalr_pc        (jalr_pc),
        .redirect_ack   (redirect_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_src   (redirect_src),
        .flush_active   (flush_active),
        .jalr_overrun   (jalr_overrun)
    );

    localparam logic [1:0] S_N = 2'd0;
    localparam logic [1:0] S_F = 2'd1;
    localparam logic [1:0] S_J = 2'd2;
    localparam logic [127:0] JP4 = {32'h400, 32'h300, 32'h200, 32'h100};

    typedef struct {
        logic         rst;
        logic         fr;
        logic [31:0]  fpc;
        logic [3:0]   jv;
        logic [127:0] jp;
        logic         ack;
        logic         ev;
        logic [31:0]  epc;
        logic [1:0]   esrc;
        logic         eovr;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  esrc;
        logic        efa;
        logic        eovr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic fr, input logic [31:0] fpc,
                                input logic [3:0] jv, input logic [127:0] jp, input logic ack,
                                input logic ev, input logic [31:0] epc, input logic [1:0] esrc,
                                input logic eovr);
        vec_t v;
        v.rst = r; v.fr = fr; v.fpc = fpc; v.jv = jv; v.jp = jp; v.ack = ack;
        v.ev = ev; v.epc = epc; v.esrc = esrc; v.eovr = eovr;
        return v;
    endfunction

    task automatic drive_idle();
        rst = 1'b0; flush_req = 1'b0; flush_pc = 32'h0;
        jalr_valid = 4'b0; jalr_pc = 128'h0; redirect_ack = 1'b0;
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, 32'(redirect_valid), 32'(e.ev));
        chk({tag, ".src"}, 32'(redirect_src), 32'(e.esrc));
        chk({tag, ".flush_active"}, 32'(flush_active), 32'(e.efa));
        chk({tag, ".overrun"}, 32'(jalr_overrun), 32'(e.eovr));
        if (e.ev)
            chk({tag, ".pc"}, redirect_pc, e.epc);
    endtask

    initial begin
        exp_t e;
        int   lat;

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset.valid", 32'(redirect_valid), 32'd0);
        chk("reset.pc", redirect_pc, 32'h0);
        chk("reset.src", 32'(redirect_src), 32'(S_N));
        chk("reset.flush_active", 32'(flush_active), 32'd0);
        chk("reset.overrun", 32'(jalr_overrun), 32'd0);

        //                 rst fr  fpc      jv       jp                          ack  ev  epc      src  ovr
        vecs.push_back(mk(0, 0, 32'h0,  4'b0010, {64'h0, 32'h200, 32'h0},   0,   0, 32'h0,   S_N, 0)); // t0
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h200, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b1111, JP4,                        0,   0, 32'h0,   S_N, 0)); // t3, rr_ptr=2
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h300, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h400, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h100, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h200, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(1, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0)); // t13 reset
        vecs.push_back(mk(0, 0, 32'h0,  4'b1111, JP4,                        0,   0, 32'h0,   S_N, 0)); // rr_ptr=0
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h100, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h200, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 1, 32'h80, 4'b0000, 128'h0,                     0,   1, 32'h300, S_J, 0)); // t20 preempt
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   1, 32'h300, S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h80,  S_F, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 1, 32'h90, 4'b0001, {96'h0, 32'hdead0000},    0,   0, 32'h0,   S_N, 0)); // t25
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h90,  S_F, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 1, 32'h70, 4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0)); // t29
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 1, 32'ha0, 4'b0000, 128'h0,                     1,   1, 32'h70,  S_F, 0)); // ack + new flush
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'ha0,  S_F, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0001, {96'h0, 32'h10},          0,   0, 32'h0,   S_N, 0)); // t34
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0100, {32'h0, 32'h500, 64'h0},  0,   1, 32'h10,  S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0100, {32'h0, 32'h600, 64'h0},  0,   1, 32'h10,  S_J, 0));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h10,  S_J, 1));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 1));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   1, 32'h600, S_J, 1));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   0, 32'h0,   S_N, 1)); // ack w/o valid
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     1,   0, 32'h0,   S_N, 1));
        vecs.push_back(mk(1, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 1));
        vecs.push_back(mk(0, 0, 32'h0,  4'b0000, 128'h0,                     0,   0, 32'h0,   S_N, 0));

        for (int t = 0; t < vecs.size(); t++) begin
            @(posedge clk);
            #1;
            rst          = vecs[t].rst;
            flush_req    = vecs[t].fr;
            flush_pc     = vecs[t].fpc;
            jalr_valid   = vecs[t].jv;
            jalr_pc      = vecs[t].jp;
            redirect_ack = vecs[t].ack;
            e.ev   = vecs[t].ev;
            e.epc  = vecs[t].epc;
            e.esrc = vecs[t].esrc;
            e.efa  = (vecs[t].esrc == S_F);
            e.eovr = vecs[t].eovr;
            sb.push_back(e);
            @(negedge clk);
            compare_pop($sformatf("vec%0d", t));
        end

        // Request-to-valid latency of a single JALR.
        @(posedge clk);
        #1;
        drive_idle();
        jalr_valid = 4'b0001;
        jalr_pc    = {96'h0, 32'h44};
        @(posedge clk);
        #1;
        drive_idle();
        lat = 1;
        while (!redirect_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency.cycles", 32'(lat), 32'd2);
        chk("latency.pc", redirect_pc, 32'h44);
        chk("latency.src", 32'(redirect_src), 32'(S_J));

        // Reset in the middle of a handshake drops the presented redirect.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst.valid%0d", k), 32'(redirect_valid), 32'd0);
            chk($sformatf("midrst.src%0d", k), 32'(redirect_src), 32'(S_N));
            chk($sformatf("midrst.pc%0d", k), redirect_pc, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
